fp_align_unit: RTL and testbench

- Front half of the FP single-precision adder; feeds the normalize/round stage.
- Accepts two IEEE-754 binary32 operands over a valid/ready handshake, then unpacks them and orders them by magnitude.
- Aligns the smaller mantissa with a multi-cycle right shifter that accumulates a sticky bit, then adds or subtracts.
- Delivers the raw 24-bit aligned result, exponent, sign and sticky bit over a second valid/ready handshake.

---
 rtl/fp_align_unit_if.sv | 27 ++
 rtl/fp_align_unit.sv | 183 ++++++++++++++++++
 tb/tb_fp_align_unit.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/fp_align_unit_if.sv
// Operand and result handshakes between the FP adder front half and its neighbours.
// slave is the alignment unit's view; master is the upstream/downstream side.
interface fp_align_unit_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] aligned_result;
    logic [7:0]  exponent_out;
    logic        aligned_sign;
    logic        sticky_bit;
    logic        out_special;

    modport slave (
        input  in_valid, op_a, op_b, out_ready,
        output in_ready, out_valid, aligned_result, exponent_out, aligned_sign, sticky_bit,
               out_special
    );

    modport master (
        output in_valid, op_a, op_b, out_ready,
        input  in_ready, out_valid, aligned_result, exponent_out, aligned_sign, sticky_bit,
               out_special
    );
endinterface

// File: rtl/fp_align_unit.sv
// FP32 adder front half: unpack, magnitude-order, multi-cycle sticky right shift of the
// smaller mantissa, then add/subtract. Normalization and rounding happen downstream.
module fp_align_unit #(
    parameter int unsigned SHIFT_PER_CYCLE = 4
) (
    input logic           clk,
    input logic           rst_n,
    fp_align_unit_if.slave bus
);
    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StCompare = 3'd1;
    localparam logic [2:0] StShift   = 3'd2;
    localparam logic [2:0] StAdd     = 3'd3;
    localparam logic [2:0] StDone    = 3'd4;

    localparam logic [4:0] StepMax = 5'(SHIFT_PER_CYCLE);

    logic [2:0]  stateQ, stateD;
    logic [31:0] opAQ, opAD, opBQ, opBD;
    logic [23:0] mantLQ, mantLD, mantSQ, mantSD;
    logic [7:0]  expLQ, expLD;
    logic        signLQ, signLD, signSQ, signSD;
    logic [4:0]  remainQ, remainD;
    logic        stickyQ, stickyD;
    logic        specialPendQ, specialPendD;
    logic [23:0] resultQ, resultD;
    logic [7:0]  expOutQ, expOutD;
    logic        signOutQ, signOutD;
    logic        stickyOutQ, stickyOutD;
    logic        specialQ, specialD;

    // Unpacked operands; exponent 0 flushes to zero
    logic [7:0]  expA, expB;
    logic [23:0] mantA, mantB;
    logic        aGeB;
    assign expA  = opAQ[30:23];
    assign expB  = opBQ[30:23];
    assign mantA = (expA == 8'd0) ? 24'd0 : {1'b1, opAQ[22:0]};
    assign mantB = (expB == 8'd0) ? 24'd0 : {1'b1, opBQ[22:0]};
    assign aGeB  = opAQ[30:0] >= opBQ[30:0];

    // Per-cycle shift step and mask of the bits that fall off the bottom
    logic [4:0]  step;
    logic [23:0] lostMask;
    assign step     = (remainQ > StepMax) ? StepMax : remainQ;
    assign lostMask = ~(24'hFF_FFFF << step);

    logic [24:0] sum;
    logic        isSub;
    assign isSub = signLQ != signSQ;
    assign sum   = isSub ? ({1'b0, mantLQ} - {1'b0, mantSQ}) : ({1'b0, mantLQ} + {1'b0, mantSQ});

    always_comb begin
        logic [7:0] expS;
        logic [7:0] diff;
        stateD       = stateQ;
        opAD         = opAQ;
        opBD         = opBQ;
        mantLD       = mantLQ;
        mantSD       = mantSQ;
        expLD        = expLQ;
        signLD       = signLQ;
        signSD       = signSQ;
        remainD      = remainQ;
        stickyD      = stickyQ;
        specialPendD = specialPendQ;
        resultD      = resultQ;
        expOutD      = expOutQ;
        signOutD     = signOutQ;
        stickyOutD   = stickyOutQ;
        specialD     = specialQ;
        expS         = 8'd0;
        diff         = 8'd0;
        case (stateQ)
            StIdle: begin
                if (bus.in_valid) begin
                    opAD   = bus.op_a;
                    opBD   = bus.op_b;
                    stateD = StCompare;
                end
            end
            StCompare: begin
                specialPendD = (expA == 8'hFF) || (expB == 8'hFF);
                if (aGeB) begin
                    mantLD = mantA;  mantSD = mantB;
                    expLD  = expA;   expS   = expB;
                    signLD = opAQ[31]; signSD = opBQ[31];
                end else begin
                    mantLD = mantB;  mantSD = mantA;
                    expLD  = expB;   expS   = expA;
                    signLD = opBQ[31]; signSD = opAQ[31];
                end
                diff    = expLD - expS;
                remainD = (diff > 8'd25) ? 5'd25 : diff[4:0];
                stickyD = 1'b0;
                // Specials still spend the ADD cycle so their latency matches d=0
                if (specialPendD || remainD == 5'd0) stateD = StAdd;
                else                                 stateD = StShift;
            end
            StShift: begin
                mantSD  = mantSQ >> step;
                stickyD = stickyQ | (|(mantSQ & lostMask));
                remainD = remainQ - step;
                if (remainQ == step) stateD = StAdd;
            end
            StAdd: begin
                resultD    = 24'd0;
                expOutD    = 8'd0;
                signOutD   = 1'b0;
                stickyOutD = 1'b0;
                specialD   = 1'b0;
                if (specialPendQ) begin
                    specialD = 1'b1;
                end else if (sum[24]) begin
                    if (8'(expLQ + 8'd1) == 8'hFF) begin
                        specialD = 1'b1;
                    end else begin
                        resultD    = sum[24:1];
                        stickyOutD = stickyQ | sum[0];
                        expOutD    = expLQ + 8'd1;
                        signOutD   = signLQ;
                    end
                end else begin
                    resultD    = sum[23:0];
                    stickyOutD = stickyQ;
                    expOutD    = expLQ;
                    signOutD   = (isSub && sum == 25'd0) ? 1'b0 : signLQ;
                end
                stateD = StDone;
            end
            StDone: begin
                if (bus.out_ready) stateD = StIdle;
            end
            default: stateD = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ       <= StIdle;
            opAQ         <= 32'd0;
            opBQ         <= 32'd0;
            mantLQ       <= 24'd0;
            mantSQ       <= 24'd0;
            expLQ        <= 8'd0;
            signLQ       <= 1'b0;
            signSQ       <= 1'b0;
            remainQ      <= 5'd0;
            stickyQ      <= 1'b0;
            specialPendQ <= 1'b0;
            resultQ      <= 24'd0;
            expOutQ      <= 8'd0;
            signOutQ     <= 1'b0;
            stickyOutQ   <= 1'b0;
            specialQ     <= 1'b0;
        end else begin
            stateQ       <= stateD;
            opAQ         <= opAD;
            opBQ         <= opBD;
            mantLQ       <= mantLD;
            mantSQ       <= mantSD;
            expLQ        <= expLD;
            signLQ       <= signLD;
            signSQ       <= signSD;
            remainQ      <= remainD;
            stickyQ      <= stickyD;
            specialPendQ <= specialPendD;
            resultQ      <= resultD;
            expOutQ      <= expOutD;
            signOutQ     <= signOutD;
            stickyOutQ   <= stickyOutD;
            specialQ     <= specialD;
        end
    end

    assign bus.in_ready       = (stateQ == StIdle);
    assign bus.out_valid      = (stateQ == StDone);
    assign bus.aligned_result = resultQ;
    assign bus.exponent_out   = expOutQ;
    assign bus.aligned_sign   = signOutQ;
    assign bus.sticky_bit     = stickyOutQ;
    assign bus.out_special    = specialQ;
endmodule

// File: tb/tb_fp_align_unit.sv
// Scoreboard bench for fp_align_unit: the driver queues hand-computed results, a negedge
// monitor compares them (fields and latency) whenever out_valid is presented.
module tb_fp_align_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fp_align_unit_if vif ();

    fp_align_unit #(.SHIFT_PER_CYCLE(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (vif.slave)
    );

    typedef struct {
        logic [23:0] res;
        logic [7:0]  expo;
        logic        sign;
        logic        sticky;
        logic        special;
        int          lat;
        int          acc;
    } expT;

    expT sbq[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    logic wasValid = 1'b0;
    logic checkReadyNext = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: compares every cycle out_valid is high, pops on handshake
    always @(negedge clk) begin
        if (!rst_n) begin
            wasValid       = 1'b0;
            checkReadyNext = 1'b0;
        end else begin
            if (checkReadyNext) begin
                check("in_ready_after_handshake", 32'(vif.in_ready), 32'd1);
                checkReadyNext = 1'b0;
            end
            if (vif.out_valid) begin
                if (sbq.size() == 0) begin
                    check("unexpected_out_valid", 32'(vif.out_valid), 32'd0);
                end else begin
                    if (!wasValid) check("latency", 32'(cyc - sbq[0].acc), 32'(sbq[0].lat));
                    check("aligned_result", 32'(vif.aligned_result), 32'(sbq[0].res));
                    check("exponent_out", 32'(vif.exponent_out), 32'(sbq[0].expo));
                    check("aligned_sign", 32'(vif.aligned_sign), 32'(sbq[0].sign));
                    check("sticky_bit", 32'(vif.sticky_bit), 32'(sbq[0].sticky));
                    check("out_special", 32'(vif.out_special), 32'(sbq[0].special));
                    check("in_ready_in_done", 32'(vif.in_ready), 32'd0);
                    if (vif.out_ready) begin
                        void'(sbq.pop_front());
                        checkReadyNext = 1'b1;
                    end
                end
            end
            wasValid = vif.out_valid;
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [23:0] r,
                        input logic [7:0] e, input logic s, input logic st, input logic sp,
                        input int lat);
        int n = 0;
        @(negedge clk);
        while (!vif.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!vif.in_ready) begin
            check("in_ready_timeout", 32'(vif.in_ready), 32'd1);
            return;
        end
        vif.in_valid = 1'b1;
        vif.op_a     = a;
        vif.op_b     = b;
        @(posedge clk);
        #1;
        vif.in_valid = 1'b0;
        sbq.push_back('{r, e, s, st, sp, lat, cyc});
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", 32'(sbq.size()), 32'd0);
        sbq.delete();
    endtask

    task automatic checkIdleOutputs(input string tag);
        check({tag, "_in_ready"}, 32'(vif.in_ready), 32'd1);
        check({tag, "_out_valid"}, 32'(vif.out_valid), 32'd0);
        check({tag, "_result"}, 32'(vif.aligned_result), 32'd0);
        check({tag, "_exponent"}, 32'(vif.exponent_out), 32'd0);
        check({tag, "_sign"}, 32'(vif.aligned_sign), 32'd0);
        check({tag, "_sticky"}, 32'(vif.sticky_bit), 32'd0);
        check({tag, "_special"}, 32'(vif.out_special), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "watchdog");
    end

    initial begin
        vif.in_valid  = 1'b0;
        vif.op_a      = 32'd0;
        vif.op_b      = 32'd0;
        vif.out_ready = 1'b1;
        #12;
        checkIdleOutputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // 1.0 + 1.0
        send(32'h3F800000, 32'h3F800000, 24'h800000, 8'd128, 1'b0, 1'b0, 1'b0, 2);
        drain();
        // 1.0 + 3.0, swapped, one shift step
        send(32'h3F800000, 32'h40400000, 24'h800000, 8'd129, 1'b0, 1'b0, 1'b0, 3);
        drain();
        // 1.0 + 2^-30, d clamped to 25 -> 7 steps
        send(32'h3F800000, 32'h30800000, 24'h800000, 8'd127, 1'b0, 1'b1, 1'b0, 9);
        drain();
        // 1.0 - 1.0
        send(32'h3F800000, 32'hBF800000, 24'h000000, 8'd127, 1'b0, 1'b0, 1'b0, 2);
        drain();
        // Inf operand
        send(32'h7F800000, 32'h3F800000, 24'h000000, 8'd0, 1'b0, 1'b0, 1'b1, 2);
        drain();
        // max finite + max finite overflows
        send(32'h7F7FFFFF, 32'h7F7FFFFF, 24'h000000, 8'd0, 1'b0, 1'b0, 1'b1, 2);
        drain();
        // 2.0 - 1.0 leaves a leading zero
        send(32'h40000000, 32'hBF800000, 24'h400000, 8'd128, 1'b0, 1'b0, 1'b0, 3);
        drain();
        // 2.0 + (1+2^-23): shifted-out 1 sets sticky
        send(32'h40000000, 32'h3F800001, 24'hC00000, 8'd128, 1'b0, 1'b1, 1'b0, 3);
        drain();
        // -2.0 + -2.0
        send(32'hC0000000, 32'hC0000000, 24'h800000, 8'd129, 1'b1, 1'b0, 1'b0, 2);
        drain();
        // 0 + 1.0: zero operand, d=127 clamped
        send(32'h00000000, 32'h3F800000, 24'h800000, 8'd127, 1'b0, 1'b0, 1'b0, 9);
        drain();
        // 1.0 + 1.5*2^-5: d=5 -> steps of 4 then 1
        send(32'h3F800000, 32'h3D400000, 24'h860000, 8'd127, 1'b0, 1'b0, 1'b0, 4);
        drain();

        // Backpressure for 5 cycles, then back-to-back second op
        vif.out_ready = 1'b0;
        send(32'h3F800000, 32'h40400000, 24'h800000, 8'd129, 1'b0, 1'b0, 1'b0, 3);
        begin
            int n = 0;
            while (!vif.out_valid && n < 50) begin
                @(posedge clk);
                #1;
                n++;
            end
            check("bp_out_valid_seen", 32'(vif.out_valid), 32'd1);
        end
        repeat (5) @(posedge clk);
        #1;
        vif.out_ready = 1'b1;
        send(32'h3F800000, 32'h3F800000, 24'h800000, 8'd128, 1'b0, 1'b0, 1'b0, 2);
        drain();

        // Asynchronous reset in the middle of SHIFT
        send(32'h3F800000, 32'h30800000, 24'h800000, 8'd127, 1'b0, 1'b1, 1'b0, 9);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkIdleOutputs("midshift_reset");
        sbq.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            check("post_reset_no_valid", 32'(vif.out_valid), 32'd0);
        end
        send(32'h3F800000, 32'h30800000, 24'h800000, 8'd127, 1'b0, 1'b1, 1'b0, 9);
        drain();

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
